// File: rtl/axis_pkg.sv
// Shared constants for the AXI4-Stream FIFO family: status pulse bit positions
// and the tuser bit that marks a frame as bad.
package axis_pkg;

    localparam int TUSER_BAD_BIT   = 0;

    localparam int STAT_OVERFLOW   = 0;
    localparam int STAT_BAD_FRAME  = 1;
    localparam int STAT_GOOD_FRAME = 2;
    localparam int STAT_W          = 3;

    typedef logic [STAT_W-1:0] stat_t;

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
// The read register holds its value while rd_en is low.
module axis_fifo_ram #(
    parameter int ADDR_WIDTH = 10,
    parameter int WIDTH      = 10
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/axis_frame_fifo.sv
// AXI4-Stream FIFO with optional store-and-forward frame mode, overflow drop and
// bad-frame drop. Two-stage read path: registered RAM read, then output register.
module axis_frame_fifo
    import axis_pkg::*;
#(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 8,
    parameter int USER_WIDTH     = 1,
    parameter int FRAME_FIFO     = 0,
    parameter int DROP_WHEN_FULL = 0,
    parameter int DROP_BAD_FRAME = 0
) (
    input  logic                  clk,
    input  logic                  nrst,

    input  logic [DATA_WIDTH-1:0] input_axis_tdata,
    input  logic                  input_axis_tvalid,
    output logic                  input_axis_tready,
    input  logic                  input_axis_tlast,
    input  logic [USER_WIDTH-1:0] input_axis_tuser,

    output logic [DATA_WIDTH-1:0] output_axis_tdata,
    output logic                  output_axis_tvalid,
    input  logic                  output_axis_tready,
    output logic                  output_axis_tlast,
    output logic [USER_WIDTH-1:0] output_axis_tuser,

    output logic [ADDR_WIDTH:0]   status_count,
    output logic                  status_overflow,
    output logic                  status_bad_frame,
    output logic                  status_good_frame
);

    localparam int WORD_W    = DATA_WIDTH + USER_WIDTH + 1;
    localparam bit IS_FRAME  = (FRAME_FIFO != 0);
    localparam bit DROP_FULL = IS_FRAME && (DROP_WHEN_FULL != 0);
    localparam bit DROP_BAD  = IS_FRAME && (DROP_BAD_FRAME != 0);

    logic [ADDR_WIDTH:0] wr_ptr_cur;
    logic [ADDR_WIDTH:0] wr_ptr_commit;
    logic [ADDR_WIDTH:0] rd_ptr;
    logic                drop_frame;
    stat_t               status_r;

    logic                full;
    logic                empty;
    logic                in_xfer;
    logic                wr_en;
    logic                rd_issue;
    logic                out_load;

    logic [WORD_W-1:0]   in_word;
    logic [WORD_W-1:0]   rd_word_p0;
    logic                vld_p0;
    logic [WORD_W-1:0]   out_word_p1;
    logic                vld_p1;

    // full compares against the speculative write pointer so a partial frame
    // cannot overwrite data still waiting to be read
    assign full  = (wr_ptr_cur[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                   (wr_ptr_cur[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
    assign empty = (wr_ptr_commit == rd_ptr);

    assign input_axis_tready = DROP_FULL ? 1'b1 : ~full;
    assign in_xfer           = input_axis_tvalid & input_axis_tready;
    assign wr_en             = in_xfer & ~full & ~drop_frame;
    assign in_word           = {input_axis_tuser, input_axis_tlast, input_axis_tdata};

    always_ff @(posedge clk) begin
        if (!nrst) begin
            wr_ptr_cur    <= '0;
            wr_ptr_commit <= '0;
            drop_frame    <= 1'b0;
            status_r      <= '0;
        end else begin
            status_r <= '0;
            if (in_xfer) begin
                if (!IS_FRAME) begin
                    wr_ptr_cur    <= wr_ptr_cur + 1'b1;
                    wr_ptr_commit <= wr_ptr_cur + 1'b1;
                end else if (full || drop_frame) begin
                    // only reachable when dropping on full: swallow up to tlast
                    wr_ptr_cur              <= wr_ptr_commit;
                    drop_frame              <= ~input_axis_tlast;
                    status_r[STAT_OVERFLOW] <= input_axis_tlast;
                end else if (input_axis_tlast && DROP_BAD &&
                             input_axis_tuser[TUSER_BAD_BIT]) begin
                    wr_ptr_cur               <= wr_ptr_commit;
                    status_r[STAT_BAD_FRAME] <= 1'b1;
                end else if (input_axis_tlast) begin
                    wr_ptr_cur                <= wr_ptr_cur + 1'b1;
                    wr_ptr_commit             <= wr_ptr_cur + 1'b1;
                    status_r[STAT_GOOD_FRAME] <= 1'b1;
                end else begin
                    wr_ptr_cur <= wr_ptr_cur + 1'b1;
                end
            end
        end
    end

    assign out_load = output_axis_tready | ~vld_p1;
    assign rd_issue = ~empty & (~vld_p0 | out_load);

    axis_fifo_ram #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .WIDTH     (WORD_W)
    ) u_ram (
        .clk    (clk),
        .wr_en  (wr_en),
        .wr_addr(wr_ptr_cur[ADDR_WIDTH-1:0]),
        .wr_data(in_word),
        .rd_en  (rd_issue),
        .rd_addr(rd_ptr[ADDR_WIDTH-1:0]),
        .rd_data(rd_word_p0)
    );

    // stage p0 -> p1: RAM read register feeds the output register
    always_ff @(posedge clk) begin
        if (!nrst) begin
            rd_ptr <= '0;
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            if (rd_issue) begin
                rd_ptr <= rd_ptr + 1'b1;
                vld_p0 <= 1'b1;
            end else if (out_load) begin
                vld_p0 <= 1'b0;
            end
            if (out_load) begin
                vld_p1 <= vld_p0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (out_load) begin
            out_word_p1 <= rd_word_p0;
        end
    end

    assign output_axis_tdata  = out_word_p1[DATA_WIDTH-1:0];
    assign output_axis_tlast  = out_word_p1[DATA_WIDTH];
    assign output_axis_tuser  = out_word_p1[WORD_W-1:DATA_WIDTH+1];
    assign output_axis_tvalid = vld_p1;

    assign status_count      = wr_ptr_commit - rd_ptr;
    assign status_overflow   = status_r[STAT_OVERFLOW];
    assign status_bad_frame  = status_r[STAT_BAD_FRAME];
    assign status_good_frame = status_r[STAT_GOOD_FRAME];

endmodule

// File: tb/tb_axis_frame_fifo.sv
// Bench for axis_frame_fifo: three depth-4 instances (word mode, frame mode with
// bad-frame drop, frame mode with drop-on-full) checked against a frame-level model.
module tb_axis_frame_fifo;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] in_tdata   [3];
    logic       in_tvalid  [3];
    logic       in_tready  [3];
    logic       in_tlast   [3];
    logic [0:0] in_tuser   [3];
    logic [7:0] out_tdata  [3];
    logic       out_tvalid [3];
    logic       out_tready [3] = '{1'b0, 1'b0, 1'b0};
    logic       out_tlast  [3];
    logic [0:0] out_tuser  [3];
    logic [2:0] cnt        [3];
    logic       ovf        [3];
    logic       bad        [3];
    logic       good       [3];
    logic [9:0] out_word   [3];

    // instance 0: word FIFO, 1: frame + bad drop, 2: frame + drop when full
    for (genvar g = 0; g < 3; g++) begin : g_dut
        axis_frame_fifo #(
            .ADDR_WIDTH    (2),
            .DATA_WIDTH    (8),
            .USER_WIDTH    (1),
            .FRAME_FIFO    ((g != 0) ? 1 : 0),
            .DROP_WHEN_FULL((g == 2) ? 1 : 0),
            .DROP_BAD_FRAME((g == 1) ? 1 : 0)
        ) u_dut (
            .clk               (clk),
            .nrst              (nrst),
            .input_axis_tdata  (in_tdata[g]),
            .input_axis_tvalid (in_tvalid[g]),
            .input_axis_tready (in_tready[g]),
            .input_axis_tlast  (in_tlast[g]),
            .input_axis_tuser  (in_tuser[g]),
            .output_axis_tdata (out_tdata[g]),
            .output_axis_tvalid(out_tvalid[g]),
            .output_axis_tready(out_tready[g]),
            .output_axis_tlast (out_tlast[g]),
            .output_axis_tuser (out_tuser[g]),
            .status_count      (cnt[g]),
            .status_overflow   (ovf[g]),
            .status_bad_frame  (bad[g]),
            .status_good_frame (good[g])
        );
        assign out_word[g] = {out_tuser[g], out_tlast[g], out_tdata[g]};
    end

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // reference model: expected output words and the frame being assembled
    logic [9:0] exp_q [$];
    logic [9:0] pend  [$];
    int         mon_sel = 0;
    int         rdy_mode [3] = '{0, 0, 0};  // 0 = stall, 1 = ready, 2 = random

    task automatic model_accept(input int i, input logic [7:0] d, input logic l, input logic u);
        logic [9:0] w;
        w = {u, l, d};
        if (i == 0) begin
            exp_q.push_back(w);
        end else begin
            pend.push_back(w);
            if (l) begin
                if (!(i == 1 && u) && !(i == 2 && pend.size() > 4)) begin
                    foreach (pend[k]) exp_q.push_back(pend[k]);
                end
                pend.delete();
            end
        end
    endtask

    task automatic send_beat(input int i, input logic [7:0] d, input logic l, input logic u);
        int   n = 0;
        logic done = 1'b0;
        in_tdata[i]  = d;
        in_tlast[i]  = l;
        in_tuser[i]  = u;
        in_tvalid[i] = 1'b1;
        while (!done && n < 200) begin
            @(negedge clk);
            done = in_tready[i];
            @(posedge clk);
            #1;
            n++;
        end
        in_tvalid[i] = 1'b0;
        if (!done) check("accept_timeout", 0, 1);
        else model_accept(i, d, l, u);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain(input int max);
        int n = 0;
        while (exp_q.size() != 0 && n < max) begin
            step(1);
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 3; i++) begin
            out_tready[i] = (rdy_mode[i] == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode[i] == 1);
        end
    end

    logic       hold_vld = 1'b0;
    logic [9:0] hold_word;

    always @(negedge clk) begin
        if (!nrst) begin
            hold_vld <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (out_tvalid[i] && out_tready[i] && i != mon_sel) check("stray_out", 1, 0);
            end
            if (hold_vld) begin
                check("hold_vld", out_tvalid[mon_sel], 1);
                check("hold_data", out_word[mon_sel], hold_word);
            end
            if (out_tvalid[mon_sel] && out_tready[mon_sel]) begin
                if (exp_q.size() == 0) check("extra_beat", 1, 0);
                else check("out_beat", out_word[mon_sel], exp_q.pop_front());
            end
            hold_vld  <= out_tvalid[mon_sel] & ~out_tready[mon_sel];
            hold_word <= out_word[mon_sel];
        end
    end

    initial begin
        #500000;
        check("watchdog", 0, 1);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog expired");
    end

    int         sent;
    int         len;
    logic       bad_fr;

    initial begin
        for (int i = 0; i < 3; i++) begin
            in_tdata[i] = '0; in_tvalid[i] = 1'b0; in_tlast[i] = 1'b0; in_tuser[i] = '0;
        end
        step(3);
        nrst = 1'b1;
        step(1);
        for (int i = 0; i < 3; i++) begin
            check("rst_tvalid", out_tvalid[i], 0);
            check("rst_count", cnt[i], 0);
            check("rst_ovf", ovf[i], 0);
            check("rst_bad", bad[i], 0);
            check("rst_good", good[i], 0);
        end

        // word mode: fill RAM plus the two read stages with the output stalled
        mon_sel = 0;
        for (int k = 0; k < 6; k++) begin
            check("w_rdy", in_tready[0], 1);
            send_beat(0, 8'((k + 1) * 17), 1'b0, 1'b0);
            check("w_status", {29'd0, ovf[0], bad[0], good[0]}, 0);
        end
        check("w_full_rdy", in_tready[0], 0);
        check("w_count_full", cnt[0], 4);
        check("w_tvalid", out_tvalid[0], 1);
        rdy_mode[0] = 1;
        wait_drain(50);
        step(1);
        check("w_count_empty", cnt[0], 0);
        check("w_rdy_after", in_tready[0], 1);

        // frame mode: nothing leaves until two edges after tlast
        mon_sel = 1;
        rdy_mode[1] = 1;
        step(1);
        send_beat(1, 8'hC1, 1'b0, 1'b0);
        check("f_no_vld1", out_tvalid[1], 0);
        send_beat(1, 8'hC2, 1'b0, 1'b0);
        check("f_no_vld2", out_tvalid[1], 0);
        send_beat(1, 8'hC3, 1'b1, 1'b0);
        check("f_good", good[1], 1);
        check("f_count", cnt[1], 3);
        check("f_no_vld3", out_tvalid[1], 0);
        step(1);
        check("f_good_once", good[1], 0);
        check("f_no_vld4", out_tvalid[1], 0);
        step(1);
        check("f_vld", out_tvalid[1], 1);
        wait_drain(50);
        step(2);

        // bad frame is discarded, the next good frame comes through intact
        send_beat(1, 8'hB1, 1'b0, 1'b0);
        send_beat(1, 8'hB2, 1'b1, 1'b1);
        check("b_bad", bad[1], 1);
        check("b_good", good[1], 0);
        check("b_count", cnt[1], 0);
        step(4);
        check("b_no_vld", out_tvalid[1], 0);
        check("b_count2", cnt[1], 0);
        send_beat(1, 8'hD1, 1'b0, 1'b0);
        send_beat(1, 8'hD2, 1'b0, 1'b0);
        send_beat(1, 8'hD3, 1'b1, 1'b0);
        check("b_good2", good[1], 1);
        wait_drain(50);

        // drop when full: oversize frame is swallowed without backpressure
        mon_sel = 2;
        for (int k = 0; k < 6; k++) begin
            check("d_rdy", in_tready[2], 1);
            send_beat(2, 8'(8'h60 + k), (k == 5), 1'b0);
        end
        check("d_ovf", ovf[2], 1);
        check("d_good", good[2], 0);
        step(1);
        check("d_ovf_once", ovf[2], 0);
        step(3);
        check("d_count", cnt[2], 0);
        check("d_no_vld", out_tvalid[2], 0);
        rdy_mode[2] = 1;
        send_beat(2, 8'hF1, 1'b0, 1'b0);
        send_beat(2, 8'hF2, 1'b1, 1'b0);
        check("d_good2", good[2], 1);
        wait_drain(50);
        rdy_mode[2] = 0;

        // random frames under random output backpressure
        mon_sel = 1;
        rdy_mode[1] = 2;
        sent = 0;
        while (sent < 1000) begin
            len    = $urandom_range(1, 4);
            bad_fr = ($urandom_range(0, 9) == 0);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 3) == 0) step(1);
                send_beat(1, 8'($urandom), (k == len - 1), (k == len - 1) && bad_fr);
                sent++;
            end
        end
        rdy_mode[1] = 1;
        wait_drain(200);
        step(1);
        check("r_count", cnt[1], 0);

        // reset mid-frame with a committed beat sitting in the output stage
        rdy_mode[1] = 0;
        step(1);
        send_beat(1, 8'hA1, 1'b1, 1'b0);
        step(3);
        check("n_vld_pre", out_tvalid[1], 1);
        send_beat(1, 8'hA2, 1'b0, 1'b0);
        send_beat(1, 8'hA3, 1'b0, 1'b0);
        nrst = 1'b0;
        step(2);
        nrst = 1'b1;
        exp_q.delete();
        pend.delete();
        check("n_vld", out_tvalid[1], 0);
        check("n_count", cnt[1], 0);
        rdy_mode[1] = 1;
        step(1);
        send_beat(1, 8'hE1, 1'b1, 1'b0);
        check("n_good", good[1], 1);
        wait_drain(50);
        step(2);
        check("n_count_end", cnt[1], 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
